hazard_forward_unit: RTL and testbench

Parametrised successor to the two-operand EX-stage forwarding logic: resolves forwarding for NPORT source operands independently, adds a writeback-history bypass register, and owns the load-use stall state machine with configurable load latency. Sits beside the ID/EX register. It drives the EX operand muxes, and drives PC/IF-ID freeze and the ID/EX bubble. Keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/forward_pkg.sv | 19 +
 rtl/hazard_forward_unit_if.sv | 35 +++
 rtl/wb_history_reg.sv | 30 +++
 rtl/hazard_forward_unit.sv | 96 +++++++++
 tb/tb_hazard_forward_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_pkg.sv
// Shared types and width defaults for the EX-stage forwarding / load-use hazard unit.
package forward_pkg;

   localparam int REGW_DEF  = 5;
   localparam int DATAW_DEF = 32;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10,
      FWD_HIST  = 2'b11
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for the hazard/forward unit: stage tags in, operand selects and stall out.
interface hazard_forward_unit_if #(
   parameter int NPORT  = 2,
   parameter int REGW   = forward_pkg::REGW_DEF,
   parameter int DATAW  = forward_pkg::DATAW_DEF,
   parameter int STAT_W = 16
);
   logic                 pipe_en;
   logic [REGW-1:0]      idex_src [NPORT];
   logic [REGW-1:0]      ifid_src [NPORT];
   logic                 idex_memrd;
   logic [REGW-1:0]      idex_wsel;
   logic                 exmem_RegWr;
   logic [REGW-1:0]      exmem_wsel;
   logic                 memwb_RegWr;
   logic [REGW-1:0]      memwb_wsel;
   logic [DATAW-1:0]     memwb_wdat;
   forward_pkg::fwd_sel_t forward [NPORT];
   logic [DATAW-1:0]     hist_dat;
   logic                 stall;
   logic                 bubble;
   logic [STAT_W-1:0]    stall_count;

   modport unit (
      input  pipe_en, idex_src, ifid_src, idex_memrd, idex_wsel,
             exmem_RegWr, exmem_wsel, memwb_RegWr, memwb_wsel, memwb_wdat,
      output forward, hist_dat, stall, bubble, stall_count
   );

   modport pipe (
      output pipe_en, idex_src, ifid_src, idex_memrd, idex_wsel,
             exmem_RegWr, exmem_wsel, memwb_RegWr, memwb_wsel, memwb_wdat,
      input  forward, hist_dat, stall, bubble, stall_count
   );
endinterface

// File: rtl/wb_history_reg.sv
// One-entry record of the last writeback (dest + data); refreshed or invalidated on each
// advancing cycle, held while the pipeline is frozen.
module wb_history_reg #(
   parameter int REGW  = 5,
   parameter int DATAW = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pipe_en,
   input  logic             wr_en,
   input  logic [REGW-1:0]  wsel,
   input  logic [DATAW-1:0] wdat,
   output logic             hist_valid,
   output logic [REGW-1:0]  hist_wsel,
   output logic [DATAW-1:0] hist_dat
);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hist_valid <= 1'b0;
         hist_wsel  <= '0;
         hist_dat   <= '0;
      end else if (pipe_en) begin
         hist_valid <= wr_en;
         if (wr_en) begin
            hist_wsel <= wsel;
            hist_dat  <= wdat;
         end
      end
   end
endmodule

// File: rtl/hazard_forward_unit.sv
// Per-operand EX forwarding select and load-use stall FSM; forward/hist_dat/stall are combinational,
// a stall lasts LOAD_LAT advancing cycles and everything holds while pipe_en is low.
module hazard_forward_unit
   import forward_pkg::*;
#(
   parameter int NPORT    = 2,
   parameter int REGW     = REGW_DEF,
   parameter int DATAW    = DATAW_DEF,
   parameter int LOAD_LAT = 1,
   parameter int STAT_W   = 16
) (
   input logic                 CLK,
   input logic                 RST,
   hazard_forward_unit_if.unit bus
);
   localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

   logic             hist_valid;
   logic [REGW-1:0]  hist_wsel;
   logic [DATAW-1:0] hist_q;
   fwd_sel_t         fwd [NPORT];
   logic             detect;
   logic             stall;
   hz_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [STAT_W-1:0] stall_q;

   wb_history_reg #(.REGW(REGW), .DATAW(DATAW)) u_hist (
      .CLK        (CLK),
      .RST        (RST),
      .pipe_en    (bus.pipe_en),
      .wr_en      (bus.memwb_RegWr),
      .wsel       (bus.memwb_wsel),
      .wdat       (bus.memwb_wdat),
      .hist_valid (hist_valid),
      .hist_wsel  (hist_wsel),
      .hist_dat   (hist_q)
   );

   // Each operand resolves on its own; nearest producer wins, $0 never forwards.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         if (bus.exmem_RegWr && bus.exmem_wsel != '0 && bus.exmem_wsel == bus.idex_src[p])
            fwd[p] = FWD_EXMEM;
         else if (bus.memwb_RegWr && bus.memwb_wsel != '0 && bus.memwb_wsel == bus.idex_src[p])
            fwd[p] = FWD_MEMWB;
         else if (hist_valid && hist_wsel != '0 && hist_wsel == bus.idex_src[p])
            fwd[p] = FWD_HIST;
         else
            fwd[p] = FWD_RF;
      end
   end

   always_comb begin
      detect = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
         if (bus.idex_wsel == bus.ifid_src[p])
            detect = 1'b1;
      end
      detect = detect && bus.idex_memrd && (bus.idex_wsel != '0);
   end

   // IDLE stall follows detect directly; WAIT covers the remaining LOAD_LAT-1 cycles.
   assign stall = !RST && ((state == WAIT) || detect);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         stall_q <= '0;
      end else if (bus.pipe_en) begin
         if (stall && stall_q != '1)
            stall_q <= stall_q + STAT_W'(1);
         case (state)
            IDLE: begin
               if (detect && LOAD_LAT > 1) begin
                  state <= WAIT;
                  cnt   <= CNT_W'(LOAD_LAT - 1);
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.forward     = fwd;
   assign bus.hist_dat    = hist_q;
   assign bus.stall       = stall;
   assign bus.bubble      = stall;
   assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: LOAD_LAT=3/STAT_W=4 and LOAD_LAT=1/STAT_W=16 instances on shared stimulus.
module tb_hazard_forward_unit;
   import forward_pkg::*;

   localparam int NP  = 2;
   localparam int RW  = 5;
   localparam int DW  = 32;
   localparam int LL0 = 3;
   localparam int SW0 = 4;
   localparam int LL1 = 1;
   localparam int SW1 = 16;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic          pipe_en, idex_memrd, exmem_RegWr, memwb_RegWr;
   logic [RW-1:0] idex_src [NP];
   logic [RW-1:0] ifid_src [NP];
   logic [RW-1:0] idex_wsel, exmem_wsel, memwb_wsel;
   logic [DW-1:0] memwb_wdat;

   hazard_forward_unit_if #(.NPORT(NP), .REGW(RW), .DATAW(DW), .STAT_W(SW0)) if0 ();
   hazard_forward_unit_if #(.NPORT(NP), .REGW(RW), .DATAW(DW), .STAT_W(SW1)) if1 ();

   assign if0.pipe_en = pipe_en;         assign if1.pipe_en = pipe_en;
   assign if0.idex_src = idex_src;       assign if1.idex_src = idex_src;
   assign if0.ifid_src = ifid_src;       assign if1.ifid_src = ifid_src;
   assign if0.idex_memrd = idex_memrd;   assign if1.idex_memrd = idex_memrd;
   assign if0.idex_wsel = idex_wsel;     assign if1.idex_wsel = idex_wsel;
   assign if0.exmem_RegWr = exmem_RegWr; assign if1.exmem_RegWr = exmem_RegWr;
   assign if0.exmem_wsel = exmem_wsel;   assign if1.exmem_wsel = exmem_wsel;
   assign if0.memwb_RegWr = memwb_RegWr; assign if1.memwb_RegWr = memwb_RegWr;
   assign if0.memwb_wsel = memwb_wsel;   assign if1.memwb_wsel = memwb_wsel;
   assign if0.memwb_wdat = memwb_wdat;   assign if1.memwb_wdat = memwb_wdat;

   hazard_forward_unit #(.NPORT(NP), .REGW(RW), .DATAW(DW), .LOAD_LAT(LL0), .STAT_W(SW0)) u0 (
      .CLK(CLK), .RST(RST), .bus(if0.unit));
   hazard_forward_unit #(.NPORT(NP), .REGW(RW), .DATAW(DW), .LOAD_LAT(LL1), .STAT_W(SW1)) u1 (
      .CLK(CLK), .RST(RST), .bus(if1.unit));

   int errors = 0;
   int checks = 0;

   // Reference model: last writeback record, remaining stall cycles per instance, stall totals.
   logic          m_hv;
   logic [RW-1:0] m_hw;
   logic [DW-1:0] m_hd;
   int rem0, rem1, cnt0, cnt1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [RW-1:0] s);
      if (s == 0) return 2'b00;
      if (exmem_RegWr && exmem_wsel == s) return 2'b10;
      if (memwb_RegWr && memwb_wsel == s) return 2'b01;
      if (m_hv && m_hw == s) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic m_detect();
      logic hit = 1'b0;
      for (int p = 0; p < NP; p++) hit |= (ifid_src[p] == idex_wsel);
      return idex_memrd && idex_wsel != 0 && hit;
   endfunction

   function automatic logic m_stall(input int rem);
      return !RST && (rem > 0 || m_detect());
   endfunction

   task automatic model_reset();
      m_hv = 1'b0; m_hw = '0; m_hd = '0;
      rem0 = 0; rem1 = 0; cnt0 = 0; cnt1 = 0;
   endtask

   task automatic model_edge();
      logic s0, s1, det;
      s0 = m_stall(rem0); s1 = m_stall(rem1); det = m_detect();
      if (RST) model_reset();
      else if (pipe_en) begin
         if (s0) cnt0 = (cnt0 < (1 << SW0) - 1) ? cnt0 + 1 : (1 << SW0) - 1;
         if (s1) cnt1 = (cnt1 < (1 << SW1) - 1) ? cnt1 + 1 : (1 << SW1) - 1;
         rem0 = (rem0 > 0) ? rem0 - 1 : (det ? LL0 - 1 : 0);
         rem1 = (rem1 > 0) ? rem1 - 1 : (det ? LL1 - 1 : 0);
         m_hv = memwb_RegWr;
         if (memwb_RegWr) begin m_hw = memwb_wsel; m_hd = memwb_wdat; end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_model();
      chk("fwd0", 32'(if0.forward[0]), 32'(m_fwd(idex_src[0])));
      chk("fwd1", 32'(if0.forward[1]), 32'(m_fwd(idex_src[1])));
      chk("fwd0_u1", 32'(if1.forward[0]), 32'(m_fwd(idex_src[0])));
      chk("hist_dat", if0.hist_dat, m_hd);
      chk("stall_u0", 32'(if0.stall), 32'(m_stall(rem0)));
      chk("bubble_u0", 32'(if0.bubble), 32'(m_stall(rem0)));
      chk("count_u0", 32'(if0.stall_count), cnt0);
      chk("stall_u1", 32'(if1.stall), 32'(m_stall(rem1)));
      chk("count_u1", 32'(if1.stall_count), cnt1);
   endtask

   task automatic clear_inputs();
      pipe_en = 1'b0; idex_memrd = 1'b0; exmem_RegWr = 1'b0; memwb_RegWr = 1'b0;
      idex_wsel = '0; exmem_wsel = '0; memwb_wsel = '0; memwb_wdat = '0;
      for (int p = 0; p < NP; p++) begin idex_src[p] = '0; ifid_src[p] = '0; end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      model_reset();
      #1;
      RST = 1'b0;
   endtask

   // Load to $4 in EX, ID reads $4 on port 1; detect held for the first `hold` cycles.
   task automatic run_load(input int n, input int hold, input logic [31:0] pe_mask, output int hi);
      hi = 0;
      clear_inputs();
      idex_wsel = 5'd4; ifid_src[0] = 5'd1; ifid_src[1] = 5'd4;
      for (int i = 0; i < n; i++) begin
         idex_memrd = (i < hold);
         pipe_en = pe_mask[i];
         #2;
         check_model();
         if (if0.stall) hi++;
         tick();
      end
      idex_memrd = 1'b0;
   endtask

   typedef struct {
      logic [RW-1:0] s0, s1;
      logic          ew;
      logic [RW-1:0] es;
      logic          mw;
      logic [RW-1:0] ms;
      logic [1:0]    f0, f1;
   } vec_t;

   vec_t tbl [7];
   int   hi;

   initial begin
      tbl[0] = '{5'd3,  5'd3, 1'b1, 5'd3,  1'b1, 5'd3, 2'b10, 2'b10};
      tbl[1] = '{5'd0,  5'd5, 1'b1, 5'd0,  1'b1, 5'd0, 2'b00, 2'b00};
      tbl[2] = '{5'd0,  5'd5, 1'b1, 5'd0,  1'b1, 5'd5, 2'b00, 2'b01};
      tbl[3] = '{5'd6,  5'd9, 1'b1, 5'd6,  1'b1, 5'd9, 2'b10, 2'b01};
      tbl[4] = '{5'd4,  5'd4, 1'b0, 5'd4,  1'b1, 5'd4, 2'b01, 2'b01};
      tbl[5] = '{5'd8,  5'd2, 1'b1, 5'd2,  1'b0, 5'd8, 2'b00, 2'b10};
      tbl[6] = '{5'd31, 5'd1, 1'b1, 5'd31, 1'b1, 5'd1, 2'b10, 2'b01};

      clear_inputs();
      RST = 1'b1;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_stall", 32'(if0.stall), 0);
      chk("rst_count", 32'(if0.stall_count), 0);
      chk("rst_hist", if0.hist_dat, 0);
      // Forwarding stays live in reset while stall is forced low.
      exmem_RegWr = 1'b1; exmem_wsel = 5'd3; idex_src[0] = 5'd3;
      idex_memrd = 1'b1; idex_wsel = 5'd3; ifid_src[0] = 5'd3;
      #1;
      chk("rst_fwd0", 32'(if0.forward[0]), 32'(2'b10));
      chk("rst_stall_det", 32'(if0.stall), 0);
      chk("rst_bubble_det", 32'(if1.bubble), 0);
      clear_inputs();
      RST = 1'b0;
      #1;

      for (int i = 0; i < 7; i++) begin
         idex_src[0] = tbl[i].s0; idex_src[1] = tbl[i].s1;
         exmem_RegWr = tbl[i].ew; exmem_wsel = tbl[i].es;
         memwb_RegWr = tbl[i].mw; memwb_wsel = tbl[i].ms;
         #2;
         chk($sformatf("tbl%0d_f0", i), 32'(if0.forward[0]), 32'(tbl[i].f0));
         chk($sformatf("tbl%0d_f1", i), 32'(if0.forward[1]), 32'(tbl[i].f1));
         tick();
      end

      // Writeback history: usable the cycle after the write, outranked by EX/MEM, dropped after a non-write.
      clear_inputs();
      pipe_en = 1'b1; memwb_RegWr = 1'b1; memwb_wsel = 5'd7; memwb_wdat = 32'hDEADBEEF;
      idex_src[0] = 5'd1; idex_src[1] = 5'd2;
      #2; check_model(); tick();
      memwb_RegWr = 1'b0; memwb_wsel = '0; memwb_wdat = '0;
      idex_src[0] = 5'd7; idex_src[1] = 5'd7;
      #2;
      chk("hist_f0", 32'(if0.forward[0]), 32'(2'b11));
      chk("hist_f1", 32'(if0.forward[1]), 32'(2'b11));
      chk("hist_dat", if0.hist_dat, 32'hDEADBEEF);
      exmem_RegWr = 1'b1; exmem_wsel = 5'd7;
      #1;
      chk("hist_vs_exmem", 32'(if0.forward[0]), 32'(2'b10));
      exmem_RegWr = 1'b0;
      tick();
      #2;
      chk("hist_cleared", 32'(if0.forward[0]), 32'(2'b00));
      chk("hist_dat_hold", if0.hist_dat, 32'hDEADBEEF);
      tick();

      // Load-use with a two-cycle freeze in the middle.
      do_reset();
      run_load(6, 1, 32'b111001, hi);
      chk("freeze_stall_len", hi, 5);
      chk("freeze_count_u0", 32'(if0.stall_count), 3);
      chk("freeze_count_u1", 32'(if1.stall_count), 1);

      // Detect held across the return to IDLE -> back-to-back stalls.
      do_reset();
      run_load(6, 6, 32'hFFFF_FFFF, hi);
      chk("b2b_stall_len", hi, 6);
      chk("b2b_count_u0", 32'(if0.stall_count), 6);
      run_load(2, 0, 32'hFFFF_FFFF, hi);
      chk("b2b_release", hi, 0);

      // Reset mid-WAIT drops stall at once; next hazard gets a full LOAD_LAT.
      do_reset();
      run_load(2, 1, 32'hFFFF_FFFF, hi);
      RST = 1'b1;
      model_reset();
      #1;
      chk("rst_wait_stall", 32'(if0.stall), 0);
      chk("rst_wait_bubble", 32'(if0.bubble), 0);
      chk("rst_wait_count", 32'(if0.stall_count), 0);
      RST = 1'b0;
      #1;
      run_load(5, 1, 32'hFFFF_FFFF, hi);
      chk("post_rst_len", hi, 3);

      // Saturation of the narrow counter.
      do_reset();
      run_load(20, 20, 32'hFFFF_FFFF, hi);
      chk("sat_count_u0", 32'(if0.stall_count), 32'hF);
      chk("sat_count_u1", 32'(if1.stall_count), 20);
      run_load(3, 0, 32'hFFFF_FFFF, hi);

      // Random traffic against the model, with occasional async reset pulses.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            idex_src[p] = RW'($urandom_range(0, 7));
            ifid_src[p] = RW'($urandom_range(0, 7));
         end
         pipe_en     = ($urandom_range(0, 3) != 0);
         idex_memrd  = ($urandom_range(0, 3) == 0);
         idex_wsel   = RW'($urandom_range(0, 7));
         exmem_RegWr = $urandom_range(0, 1) == 1;
         exmem_wsel  = RW'($urandom_range(0, 7));
         memwb_RegWr = $urandom_range(0, 1) == 1;
         memwb_wsel  = RW'($urandom_range(0, 7));
         memwb_wdat  = $urandom;
         if ($urandom_range(0, 63) == 0) begin
            RST = 1'b1;
            model_reset();
         end else begin
            RST = 1'b0;
         end
         #2;
         check_model();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
